// File: rtl/term_net_bridge_if.sv
// Handshake bundle between a terminal-bus driver and the term_net_bridge.
// The master side drives words in and consumes words out; the slave side is the bridge.
interface term_net_bridge_if #(
    parameter int WIDTH   = 32,
    parameter int SRC_LSB = 0,
    parameter int DEPTH   = 2,
    parameter int CW      = $clog2(DEPTH + 1)
);
    logic                            flush;
    logic                            in_valid;
    logic                            in_ready;
    logic [SRC_LSB+WIDTH-1:SRC_LSB]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [WIDTH-1:0]                out_data;
    logic [CW-1:0]                   count;
    logic                            drop_err;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, drop_err
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, drop_err
    );
endinterface

// File: rtl/term_net_bridge.sv
// Remaps an offset-indexed terminal bus onto a zero-based net bus and retimes it
// through a DEPTH-entry valid/ready FIFO with a registered output word.
module term_net_bridge #(
    parameter int WIDTH   = 32,
    parameter int SRC_LSB = 0,
    parameter int REVERSE = 0,
    parameter int DEPTH   = 2,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    term_net_bridge_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [WIDTH-1:0] remap(input logic [SRC_LSB+WIDTH-1:SRC_LSB] src);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (REVERSE != 0) ? src[SRC_LSB+WIDTH-1-i] : src[SRC_LSB+i];
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             drop_err_q, drop_err_d;

    logic [WIDTH-1:0] mapped;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;

    always_comb begin
        mapped      = remap(bus.in_data);
        full        = (count_q == CW'(DEPTH));
        push        = bus.in_valid && !full;
        pop         = out_valid_q && bus.out_ready;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_en       = 1'b0;
        drop_err_d  = drop_err_q | (bus.in_valid & full);

        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            wr_en = push;
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            out_valid_d = (count_d != '0);
            // The new head is the incoming word only when nothing older remains after this pop.
            if (count_d != '0) begin
                if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
                    out_data_d = mapped;
                end else begin
                    out_data_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // Storage carries no reset; occupancy is governed entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= mapped;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_term_net_bridge.sv
// Directed bench for term_net_bridge: three configurations, queue-based reference models
// checked every cycle, plus hand-computed literal expectations.
module tb_term_net_bridge;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   model_on = 0;

    term_net_bridge_if #(.WIDTH(32), .SRC_LSB(0), .DEPTH(2)) ifa ();
    term_net_bridge_if #(.WIDTH(1),  .SRC_LSB(1), .DEPTH(1)) ifb ();
    term_net_bridge_if #(.WIDTH(8),  .SRC_LSB(2), .DEPTH(3)) ifc ();

    term_net_bridge #(.WIDTH(32), .SRC_LSB(0), .REVERSE(0), .DEPTH(2))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    term_net_bridge #(.WIDTH(1),  .SRC_LSB(1), .REVERSE(0), .DEPTH(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    term_net_bridge #(.WIDTH(8),  .SRC_LSB(2), .REVERSE(1), .DEPTH(3))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        r = {<<{v}};
        return r;
    endfunction

    // Reference models: a queue of words, a sticky flag and the last head shown.
    logic [31:0] qa[$];
    logic [31:0] last_a;
    bit          drop_a;
    logic [7:0]  qc[$];
    logic [7:0]  last_c;
    bit          drop_c;

    always @(posedge clk) begin
        bit rdy, push, pop;
        rdy  = (qa.size() != 2);
        push = ifa.in_valid && rdy;
        pop  = (qa.size() != 0) && ifa.out_ready;
        if (!rst_n) begin
            qa.delete();
            drop_a = 0;
            last_a = '0;
        end else begin
            if (ifa.in_valid && !rdy) drop_a = 1;
            if (ifa.flush) qa.delete();
            else begin
                if (pop)  void'(qa.pop_front());
                if (push) qa.push_back(ifa.in_data);
            end
            if (qa.size() != 0) last_a = qa[0];
        end
    end

    always @(posedge clk) begin
        bit rdy, push, pop;
        logic [7:0] w;
        rdy  = (qc.size() != 3);
        push = ifc.in_valid && rdy;
        pop  = (qc.size() != 0) && ifc.out_ready;
        w    = ifc.in_data;
        if (!rst_n) begin
            qc.delete();
            drop_c = 0;
            last_c = '0;
        end else begin
            if (ifc.in_valid && !rdy) drop_c = 1;
            if (ifc.flush) qc.delete();
            else begin
                if (pop)  void'(qc.pop_front());
                if (push) qc.push_back(rev8(w));
            end
            if (qc.size() != 0) last_c = qc[0];
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("a_out_valid", ifa.out_valid, qa.size() != 0);
            chk("a_in_ready",  ifa.in_ready,  qa.size() != 2);
            chk("a_count",     ifa.count,     qa.size());
            chk("a_drop_err",  ifa.drop_err,  drop_a);
            chk("a_out_data",  ifa.out_data,  last_a);
            chk("c_out_valid", ifc.out_valid, qc.size() != 0);
            chk("c_in_ready",  ifc.in_ready,  qc.size() != 3);
            chk("c_count",     ifc.count,     qc.size());
            chk("c_drop_err",  ifc.drop_err,  drop_c);
            chk("c_out_data",  ifc.out_data,  last_c);
        end
    end

    initial begin
        int sent, recv;
        bit acc, fire;
        rst_n = 1'b0;
        ifa.flush = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ready = 0;
        ifb.flush = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ready = 0;
        ifc.flush = 0; ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = 0;
        step();
        step();
        model_on = 1;
        rst_n = 1'b1;
        chk("rst_count",     ifa.count,     0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data",  ifa.out_data,  0);
        chk("rst_drop_err",  ifa.drop_err,  0);
        chk("rst_in_ready",  ifa.in_ready,  1);

        // Offset map: source bit 1 lands on destination bit 0.
        ifb.in_data = 1'b1; ifb.in_valid = 1;
        step();
        ifb.in_valid = 0;
        chk("b_out_valid", ifb.out_valid, 1);
        chk("b_out_data",  ifb.out_data,  1);
        chk("b_count",     ifb.count,     1);
        chk("b_in_ready",  ifb.in_ready,  0);

        // Straight map with immediate consumption.
        ifa.in_valid = 1; ifa.in_data = 32'hDEADBEEF; ifa.out_ready = 1;
        step();
        ifa.in_valid = 0;
        chk("straight_valid", ifa.out_valid, 1);
        chk("straight_data",  ifa.out_data,  32'hDEADBEEF);
        chk("straight_count", ifa.count,     1);
        step();
        chk("straight_drain", ifa.count,     0);
        chk("empty_hold",     ifa.out_data,  32'hDEADBEEF);

        // Fill to DEPTH=2 under back-pressure, then drain in order.
        ifa.out_ready = 0;
        ifa.in_valid = 1; ifa.in_data = 32'h11111111;
        step();
        ifa.in_data = 32'h22222222;
        step();
        chk("full_count",    ifa.count,    2);
        chk("full_in_ready", ifa.in_ready, 0);
        chk("full_head",     ifa.out_data, 32'h11111111);
        ifa.in_data = 32'h33333333;
        step();
        ifa.in_valid = 0;
        chk("drop_set",      ifa.drop_err, 1);
        chk("drop_count",    ifa.count,    2);
        ifa.out_ready = 1;
        step();
        chk("pop1_data",     ifa.out_data, 32'h22222222);
        chk("pop1_in_ready", ifa.in_ready, 1);
        chk("pop1_count",    ifa.count,    1);
        step();
        chk("pop2_valid",    ifa.out_valid, 0);
        ifa.out_ready = 0;

        // Simultaneous push and pop at count=1.
        ifa.in_valid = 1; ifa.in_data = 32'hC0C0C0C0;
        step();
        ifa.in_data = 32'hD0D0D0D0; ifa.out_ready = 1;
        step();
        ifa.in_valid = 0;
        chk("simul_count", ifa.count,    1);
        chk("simul_data",  ifa.out_data, 32'hD0D0D0D0);
        step();
        ifa.out_ready = 0;

        // Flush at count=2 keeps drop_err and the last output word.
        ifa.in_valid = 1; ifa.in_data = 32'hE0E0E0E0;
        step();
        ifa.in_data = 32'hF0F0F0F0;
        step();
        ifa.in_valid = 0;
        chk("preflush_count", ifa.count, 2);
        ifa.flush = 1;
        step();
        ifa.flush = 0;
        chk("flush_count", ifa.count,     0);
        chk("flush_valid", ifa.out_valid, 0);
        chk("flush_drop",  ifa.drop_err,  1);
        chk("flush_data",  ifa.out_data,  32'hE0E0E0E0);

        // Reset mid-stream.
        ifa.in_valid = 1; ifa.in_data = 32'h12345678;
        step();
        ifa.in_valid = 0;
        chk("prerst_count", ifa.count, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mrst_count", ifa.count,     0);
        chk("mrst_valid", ifa.out_valid, 0);
        chk("mrst_data",  ifa.out_data,  0);
        chk("mrst_drop",  ifa.drop_err,  0);
        chk("mrst_b_cnt", ifb.count,     0);

        // Reverse map on the 8-bit instance sourced from [9:2].
        ifc.in_valid = 1; ifc.in_data = 8'h01; ifc.out_ready = 1;
        step();
        chk("rev_01", ifc.out_data, 8'h80);
        ifc.in_data = 8'hC3;
        step();
        chk("rev_c3", ifc.out_data, 8'hC3);
        ifc.in_valid = 0;
        step();
        ifc.out_ready = 0;

        // A push in the flush cycle is discarded.
        ifc.in_valid = 1; ifc.in_data = 8'h0F;
        step();
        chk("c_pre_count", ifc.count, 1);
        ifc.flush = 1; ifc.in_data = 8'hAA;
        step();
        ifc.flush = 0; ifc.in_valid = 0;
        chk("c_flush_count", ifc.count,    0);
        chk("c_flush_data",  ifc.out_data, 8'hF0);
        step();
        chk("c_flush_nopush", ifc.count, 0);

        // Ten words through DEPTH=3 with irregular back-pressure: wrap, no loss, no reorder.
        sent = 0;
        recv = 0;
        for (int k = 0; k < 60 && recv < 10; k++) begin
            ifc.in_valid  = (sent < 10);
            ifc.in_data   = 8'(sent * 29 + 3);
            ifc.out_ready = (k % 3 != 0);
            acc  = ifc.in_valid && ifc.in_ready;
            fire = ifc.out_valid && ifc.out_ready;
            if (fire) chk("wrap_order", ifc.out_data, rev8(8'(recv * 29 + 3)));
            step();
            if (acc)  sent++;
            if (fire) recv++;
        end
        ifc.in_valid = 0; ifc.out_ready = 0;
        chk("wrap_recv", recv, 10);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
